// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, runs one outstanding fetch on the
// req/addr_ok/data_ok instruction port, and hands {pc,inst} to ID.
module if_stage #(
    parameter logic [31:0] RESET_PC     = 32'h1c000000,
    parameter int          IF_to_ID_LEN = 64,
    parameter int          BR_BUS_LEN   = 34
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    ID_allowin,
    input  logic [BR_BUS_LEN-1:0]   BR_BUS,
    output logic                    IF_to_ID_valid,
    output logic [IF_to_ID_LEN-1:0] IF_to_ID_BUS,
    output logic                    inst_sram_req,
    output logic                    inst_sram_wr,
    output logic [1:0]              inst_sram_size,
    output logic [3:0]              inst_sram_wstrb,
    output logic [31:0]             inst_sram_addr,
    output logic [31:0]             inst_sram_wdata,
    input  logic                    inst_sram_addr_ok,
    input  logic                    inst_sram_data_ok,
    input  logic [31:0]             inst_sram_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

    state_t      state, nxt;
    logic [31:0] pc, req_pc, inst_buf;
    logic        discard;

    logic [31:0] br_target;
    logic        br_cancel;
    logic        unused_br_taken;
    logic        fire;

    // br_taken alone means ID is stalled; only the cancel bit acts here.
    assign br_target       = BR_BUS[BR_BUS_LEN-1 -: 32];
    assign br_cancel       = BR_BUS[0];
    assign unused_br_taken = BR_BUS[1];

    assign fire = (state == S_REQ) && inst_sram_addr_ok;

    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'd2;
    assign inst_sram_wstrb = 4'h0;
    assign inst_sram_wdata = 32'h0;
    assign inst_sram_addr  = pc;
    assign IF_to_ID_BUS    = {req_pc, inst_buf};

    always_comb begin
        nxt = state;
        case (state)
            S_IDLE: nxt = S_REQ;
            S_REQ:  if (inst_sram_addr_ok) nxt = S_WAIT;
            S_WAIT: if (inst_sram_data_ok) nxt = (discard || br_cancel) ? S_REQ : S_HOLD;
            S_HOLD: if (ID_allowin || br_cancel) nxt = S_REQ;
            default: nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state          <= S_IDLE;
            pc             <= RESET_PC;
            req_pc         <= 32'h0;
            inst_buf       <= 32'h0;
            discard        <= 1'b0;
            inst_sram_req  <= 1'b0;
            IF_to_ID_valid <= 1'b0;
        end else begin
            state          <= nxt;
            inst_sram_req  <= (nxt == S_REQ);
            IF_to_ID_valid <= (nxt == S_HOLD);

            // A redirect overrides the sequential increment, even on an accepted fetch.
            if (br_cancel)
                pc <= br_target;
            else if (fire)
                pc <= pc + 32'd4;

            if (fire)
                req_pc <= pc;

            if (state == S_WAIT && inst_sram_data_ok && !discard && !br_cancel)
                inst_buf <= inst_sram_rdata;

            // discard marks the in-flight response as wrong-path.
            if (fire && br_cancel)
                discard <= 1'b1;
            else if (state == S_WAIT) begin
                if (inst_sram_data_ok)
                    discard <= 1'b0;
                else if (br_cancel)
                    discard <= 1'b1;
            end
        end
    end

    a_no_orphan_data: assert property (@(posedge clk) disable iff (!resetn)
        inst_sram_data_ok |-> (state == S_WAIT));

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: latency-programmable slave, handoff/accept monitors.
module tb_if_stage;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        ID_allowin = 1'b1;
    logic [33:0] BR_BUS = 34'h0;
    logic        IF_to_ID_valid;
    logic [63:0] IF_to_ID_BUS;
    logic        inst_sram_req, inst_sram_wr;
    logic [1:0]  inst_sram_size;
    logic [3:0]  inst_sram_wstrb;
    logic [31:0] inst_sram_addr, inst_sram_wdata;
    logic        inst_sram_addr_ok, inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    logic        w_valid, w_req, w_wr, w_dok;
    logic [63:0] w_bus;
    logic [1:0]  w_size;
    logic [3:0]  w_wstrb;
    logic [31:0] w_addr, w_wdata;
    logic [31:0] w_rdata = 32'h12345678;

    int          lat = 1;
    logic        aok_en = 1'b1;
    int          total = 0, bad = 0, cyc = 0, vld_cnt = 0;
    logic [63:0] ho_q[$], w_q[$];
    int          ho_cyc[$];
    logic [31:0] acc_q[$], acc2[$];

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .resetn(resetn), .ID_allowin(ID_allowin), .BR_BUS(BR_BUS),
        .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_BUS(IF_to_ID_BUS),
        .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
        .inst_sram_size(inst_sram_size), .inst_sram_wstrb(inst_sram_wstrb),
        .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
        .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata(inst_sram_rdata)
    );

    if_stage #(.RESET_PC(32'hfffffffc)) u_wrap (
        .clk(clk), .resetn(resetn), .ID_allowin(1'b1), .BR_BUS(34'h0),
        .IF_to_ID_valid(w_valid), .IF_to_ID_BUS(w_bus),
        .inst_sram_req(w_req), .inst_sram_wr(w_wr),
        .inst_sram_size(w_size), .inst_sram_wstrb(w_wstrb),
        .inst_sram_addr(w_addr), .inst_sram_wdata(w_wdata),
        .inst_sram_addr_ok(w_req), .inst_sram_data_ok(w_dok),
        .inst_sram_rdata(w_rdata)
    );

    assign inst_sram_addr_ok = inst_sram_req & aok_en;

    // Slave: data_ok arrives lat cycles after the accepting cycle; word = addr + 0x10000000.
    logic        pend;
    int          cnt;
    logic [31:0] paddr;
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pend <= 1'b0; cnt <= 0; paddr <= 32'h0;
            inst_sram_data_ok <= 1'b0; inst_sram_rdata <= 32'h0;
        end else begin
            inst_sram_data_ok <= 1'b0;
            if (pend && cnt == 1) begin
                inst_sram_data_ok <= 1'b1;
                inst_sram_rdata   <= paddr + 32'h10000000;
                pend <= 1'b0;
            end else if (pend)
                cnt <= cnt - 1;
            if (inst_sram_req && inst_sram_addr_ok) begin
                if (lat == 1) begin
                    inst_sram_data_ok <= 1'b1;
                    inst_sram_rdata   <= inst_sram_addr + 32'h10000000;
                end else begin
                    pend <= 1'b1; cnt <= lat - 1; paddr <= inst_sram_addr;
                end
            end
        end
    end

    always @(posedge clk or negedge resetn)
        if (!resetn) w_dok <= 1'b0;
        else         w_dok <= w_req;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (resetn) begin
            if (IF_to_ID_valid && ID_allowin) begin
                ho_q.push_back(IF_to_ID_BUS);
                ho_cyc.push_back(cyc);
            end
            if (IF_to_ID_valid) vld_cnt++;
            if (inst_sram_req && inst_sram_addr_ok) acc_q.push_back(inst_sram_addr);
            if (w_req) acc2.push_back(w_addr);
            if (w_valid) w_q.push_back(w_bus);
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int l);
        resetn = 1'b0; ID_allowin = 1'b1; BR_BUS = 34'h0; aok_en = 1'b1; lat = l;
        repeat (3) @(posedge clk);
        #1;
        ho_q.delete(); ho_cyc.delete(); acc_q.delete(); acc2.delete(); w_q.delete();
        vld_cnt = 0;
        @(negedge clk);
        resetn = 1'b1;
        #1;
    endtask

    task automatic wait_ho(input int n, input string tag);
        for (int i = 0; i < 60 && ho_q.size() < n; i++) tick();
        chk(tag, 64'(ho_q.size() >= n), 64'd1);
    endtask

    task automatic wait_req(input string tag);
        for (int i = 0; i < 30 && !inst_sram_req; i++) tick();
        chk(tag, {63'd0, inst_sram_req}, 64'd1);
    endtask

    task automatic wait_vld(input string tag);
        for (int i = 0; i < 30 && !IF_to_ID_valid; i++) tick();
        chk(tag, {63'd0, IF_to_ID_valid}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        // T1: reset state and first request timing
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t1_rst_req", {63'd0, inst_sram_req}, 64'd0);
        chk("t1_rst_vld", {63'd0, IF_to_ID_valid}, 64'd0);
        chk("t1_rst_bus", IF_to_ID_BUS, 64'd0);
        chk("t1_tied", {51'd0, inst_sram_wr, inst_sram_size, inst_sram_wstrb}, {51'd0, 1'b0, 2'd2, 4'h0});
        do_reset(1);
        chk("t1_idle_req", {63'd0, inst_sram_req}, 64'd0);
        tick();
        chk("t1_first_req", {63'd0, inst_sram_req}, 64'd1);
        chk("t1_first_addr", {32'd0, inst_sram_addr}, 64'h1c000000);

        // T2: straight line, zero-wait slave
        wait_ho(3, "t2_wait");
        chk("t2_ho0", ho_q[0], {32'h1c000000, 32'h2c000000});
        chk("t2_ho1", ho_q[1], {32'h1c000004, 32'h2c000004});
        chk("t2_ho2", ho_q[2], {32'h1c000008, 32'h2c000008});
        chk("t2_gap01", 64'(ho_cyc[1] - ho_cyc[0]), 64'd3);
        chk("t2_gap12", 64'(ho_cyc[2] - ho_cyc[1]), 64'd3);
        chk("wrap_addr0", {32'd0, acc2[0]}, 64'hfffffffc);
        chk("wrap_addr1", {32'd0, acc2[1]}, 64'h0);
        chk("wrap_ho0", w_q[0], {32'hfffffffc, 32'h12345678});

        // T3: backpressure in HOLD, then T6: redirect in HOLD
        do_reset(1);
        wait_ho(1, "t3_first");
        ID_allowin = 1'b0;
        wait_vld("t3_hold");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("t3_bus", IF_to_ID_BUS, {32'h1c000004, 32'h2c000004});
            chk("t3_vld", {63'd0, IF_to_ID_valid}, 64'd1);
            chk("t3_noreq", {63'd0, inst_sram_req}, 64'd0);
        end
        chk("t3_acc_cnt", 64'(acc_q.size()), 64'd2);
        ID_allowin = 1'b1;
        tick();
        chk("t3_req", {63'd0, inst_sram_req}, 64'd1);
        chk("t3_addr", {32'd0, inst_sram_addr}, 64'h1c000008);
        chk("t3_ho1", ho_q[1], {32'h1c000004, 32'h2c000004});
        ID_allowin = 1'b0;
        wait_vld("t6_hold");
        chk("t6_held", IF_to_ID_BUS, {32'h1c000008, 32'h2c000008});
        BR_BUS = {32'h1c000300, 1'b1, 1'b1};
        tick();
        BR_BUS = 34'h0;
        chk("t6_vld_drop", {63'd0, IF_to_ID_valid}, 64'd0);
        chk("t6_req", {63'd0, inst_sram_req}, 64'd1);
        chk("t6_addr", {32'd0, inst_sram_addr}, 64'h1c000300);
        ID_allowin = 1'b1;
        wait_ho(3, "t6_wait");
        chk("t6_ho", ho_q[2], {32'h1c000300, 32'h2c000300});

        // T4: redirect while waiting on a slow slave
        do_reset(4);
        tick();
        chk("t4_req", {63'd0, inst_sram_req}, 64'd1);
        tick();
        tick();
        BR_BUS = {32'h1c000100, 1'b1, 1'b1};
        tick();
        BR_BUS = 34'h0;
        wait_req("t4_rereq");
        chk("t4_addr", {32'd0, inst_sram_addr}, 64'h1c000100);
        chk("t4_no_vld", 64'(vld_cnt), 64'd0);
        wait_ho(1, "t4_wait");
        chk("t4_ho", ho_q[0], {32'h1c000100, 32'h2c000100});
        chk("t4_acc1", {32'd0, acc_q[1]}, 64'h1c000100);

        // T5: redirect coincident with addr_ok
        do_reset(1);
        wait_ho(2, "t5_two");
        chk("t5_req", {63'd0, inst_sram_req}, 64'd1);
        chk("t5_addr", {32'd0, inst_sram_addr}, 64'h1c000008);
        BR_BUS = {32'h1c000200, 1'b1, 1'b1};
        tick();
        BR_BUS = 34'h0;
        wait_ho(3, "t5_wait");
        chk("t5_ho", ho_q[2], {32'h1c000200, 32'h2c000200});
        chk("t5_acc2", {32'd0, acc_q[2]}, 64'h1c000008);
        chk("t5_acc3", {32'd0, acc_q[3]}, 64'h1c000200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
